// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the MEM-stage data memory access unit.
package mem_access_unit_pkg;

    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_CACHE = 2'd1;
    localparam logic [1:0] WB_CSR   = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects and sign/zero-extends the loaded byte/halfword/word from a read word.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // addr_lo[0] is deliberately ignored for halfwords
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        data = word;
        case (load_type)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            LW:      data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access FSM: issues one registered request per op, stalls
// the pipeline until ack, and returns the extended load result to WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wb_select_MEM,
    input  logic [2:0]  load_type_MEM,
    input  logic [3:0]  cache_write_en_MEM,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic        flushM,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data_WB,
    output logic [31:0] perf_access_cnt,
    output logic [31:0] perf_stall_cnt
);

    mau_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ltype_q, ltype_d;
    logic        kill_q, kill_d;
    logic [31:0] load_q, load_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] stl_q, stl_d;
    logic        access;
    logic        stall;
    logic [31:0] ext_data;

    assign access = (wb_select_MEM == WB_CACHE) || (cache_write_en_MEM != 4'd0);

    load_extend u_load_extend (
        .load_type (ltype_q),
        .addr_lo   (addr_q[1:0]),
        .word      (mem_rdata),
        .data      (ext_data)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ltype_d = ltype_q;
        kill_d  = kill_q;
        load_d  = load_q;
        acc_d   = acc_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && !flushM) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = cache_write_en_MEM;
                    addr_d  = addr_MEM;
                    wdata_d = store_data_MEM;
                    ltype_d = load_type_MEM;
                    kill_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                // a flushed op still runs to completion; only its write-back is dropped
                if (flushM) begin
                    kill_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                    acc_d   = acc_q + 32'd1;
                    if ((ltype_q != NOREGWRITE) && !kill_q && !flushM) begin
                        load_d = ext_data;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        stl_d = stall ? (stl_q + 32'd1) : stl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ltype_q <= NOREGWRITE;
            kill_q  <= 1'b0;
            load_q  <= 32'd0;
            acc_q   <= 32'd0;
            stl_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ltype_q <= ltype_d;
            kill_q  <= kill_d;
            load_q  <= load_d;
            acc_q   <= acc_d;
            stl_q   <= stl_d;
        end
    end

    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = {addr_q[31:2], 2'b00};
    assign mem_wdata       = wdata_q;
    assign mem_stall       = stall;
    assign load_data_WB    = load_q;
    assign perf_access_cnt = acc_q;
    assign perf_stall_cnt  = stl_q;

endmodule
